divide_seq: RTL and testbench
=============================

// Module: divide_seq
// PURPOSE
// - Sequential restoring divider: inverse of the combinational multiplier in the ALU datapath.
// - Produces quotient and remainder of dividend/divisor, one quotient bit per clock.
// - Sits beside the multiplier behind the ALU. The control unit launches it with start and stalls on busy.
// - Supports unsigned and signed (two's complement) division.
// PARAMETERS
// WIDTH      32   operand/result width in bits (>= 2)
// PORTS
// clk          in   1      rising-edge clock
// rst          in   1      synchronous, active-high reset
// start        in   1      launch request; sampled only in IDLE
// signed_op    in   1      1 = signed divide, 0 = unsigned; sampled with start
// dividend     in   WIDTH  numerator; sampled with start
// divisor      in   WIDTH  denominator; sampled with start
// busy         out  1      high while a division is in progress (CALC)
// done         out  1      one-cycle pulse; results valid
// quotient     out  WIDTH  result quotient; held until next accepted start
// remainder    out  WIDTH  result remainder; held until next accepted start
// div_by_zero  out  1      set with done when divisor == 0; held like results
// BEHAVIOUR
// - Reset (any state): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
// - Reset mid-CALC aborts the operation; no done is produced.
// - FSM states:
//   - IDLE: start=1 latches the operands.
//     - If divisor==0, go to DONE.
//     - Otherwise go to CALC with busy=1 and counter=WIDTH.
//   - CALC: one restoring step per cycle (details below). Decrement counter; when it reaches 0, go to DONE.
//   - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE unconditionally.
// - start is ignored in CALC and DONE. Back-to-back operations need one IDLE cycle between them.
// - Latency, with start sampled at edge E:
//   - Normal divide: busy high from E+1 for WIDTH cycles; done high in the cycle after edge E+WIDTH+1.
//   - Divide by zero: done high in the cycle after edge E+1; busy never rises.
// - Restoring step:
//   - Form {R,Q} = {R,Q} << 1.
//   - If R >= D, then R = R - D and Q[0] = 1.
//   - R is WIDTH+1 bits internally to hold the borrow.
// - Signed mode:
//   - Operate on magnitudes |dividend| and |divisor|, taken as WIDTH-bit unsigned values.
//   - Quotient sign = dividend sign XOR divisor sign.
//   - Remainder sign = dividend sign; a zero remainder stays 0.
//   - Overflow case MIN / -1 gives quotient = MIN, remainder = 0, with no flag.
// - Divide by zero (either mode): quotient = all ones, remainder = dividend, div_by_zero = 1.
// - Invariant (non-zero divisor): dividend == quotient*divisor + remainder (mod 2^WIDTH).
//   - |remainder| < |divisor|.
// - Outputs update only on the transition into DONE. They are stable in IDLE and CALC.
// - An accepted start clears div_by_zero.
// TESTING
// - Unsigned 100/7 (signed_op=0): done exactly 33 cycles after start; quotient=14, remainder=2, div_by_zero=0.
// - Signed -7/2: quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF).
//   - Signed 7/-2: quotient=-3, remainder=1.
// - Divisor 0 with dividend=0x1234: done 1 cycle after start; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1; busy stays 0.
// - Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
//   - Unsigned 0xFFFFFFFF/1: quotient=0xFFFFFFFF, remainder=0.
// - Drive start=1 with new operands during CALC and during DONE: both ignored; the first result is unchanged and only one done pulse occurs.
// - Assert rst at CALC cycle 10: next cycle busy=0, outputs=0, no done.
//   - Then issue 9/3: quotient=3, remainder=0.

Source files
------------

// File: rtl/divide_seq.sv
// Sequential restoring divider: one quotient bit per clock, unsigned or signed
// (two's complement) operands, quotient/remainder/div-by-zero held until the next result.
module divide_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted only while IDLE (operands and signed_op are
  // captured on that edge); busy is high for every CALC step; done is a one-cycle
  // pulse with quotient/remainder/div_by_zero valid, and those stay held afterwards.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign dividend_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The shifted partial remainder needs one extra bit; after a successful
  // subtract the result is below the divisor, so WIDTH bits suffice to keep it.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign ge       = (rem_sh >= {1'b0, den_q});
  assign step_rem = ge ? (rem_sh[WIDTH-1:0] - den_q) : rem_sh[WIDTH-1:0];

  assign q_fin = qneg_q ? -quo_q : quo_q;
  assign r_fin = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    num_d   = num_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d  = dividend;
          den_d  = divisor_mag;
          quo_d  = dividend_mag;
          rem_d  = '0;
          qneg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d = signed_op & dividend[WIDTH-1];
          dz_d   = (divisor == '0);
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      CALC: begin
        busy_d = 1'b1;
        rem_d  = step_rem;
        quo_d  = {quo_q[WIDTH-2:0], ge};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          quot_d = '1;
          remo_d = num_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_fin;
          remo_d = r_fin;
          dbz_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
      num_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      den_q   <= den_d;
      num_q   <= num_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_divide_seq.sv
// Bench for divide_seq: directed corner cases plus random operands, results
// checked by a scoreboard against plain-arithmetic division.
module tb_divide_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic         exp_z_q[$];

  int n_cmp = 0;
  int n_err = 0;

  divide_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // reference model: ordinary integer division on 64-bit signed values
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb, sq, sr;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
      z  = 1'b0;
    end
  endtask

  // monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        chk("quotient", quotient, exp_q.pop_front());
        chk("remainder", remainder, exp_r_q.pop_front());
        chk("div_by_zero", W'(div_by_zero), W'(exp_z_q.pop_front()));
      end
    end
  end

  // driver: issue one divide; ign=1 also pokes start during CALC and DONE
  task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit ign);
    logic [W-1:0] q, r;
    logic z;
    int lat, busy_cnt;
    bit got;
    model(s, a, b, q, r, z);
    exp_q.push_back(q);
    exp_r_q.push_back(r);
    exp_z_q.push_back(z);
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cnt = 0; got = 0;
    while (!got && lat < 100) begin
      if (ign) begin
        start     = (lat == 5 || lat == W);
        signed_op = 1'($urandom_range(1));
        dividend  = $urandom;
        divisor   = $urandom | 32'd1;
      end
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    chk("latency", W'(lat), (b == '0) ? W'(1) : W'(W + 1));
    chk("busy_cycles", W'(busy_cnt), (b == '0) ? W'(0) : W'(W));
    @(negedge clk);
    chk("done_single_pulse", W'(done), W'(0));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_abort(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("busy_before_abort", W'(busy), W'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_quotient", quotient, W'(0));
    chk("abort_remainder", remainder, W'(0));
    chk("abort_dbz", W'(div_by_zero), W'(0));
    chk("abort_state", W'(state_dbg), W'(0));
    rst = 1'b0;
    idle_cycles(W + 8);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic s;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_quotient", quotient, W'(0));
    chk("reset_remainder", remainder, W'(0));
    chk("reset_dbz", W'(div_by_zero), W'(0));
    chk("reset_state", W'(state_dbg), W'(0));
    rst = 1'b0;
    @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, -32'sd7, 32'd2, 0);
    run_div(1'b1, 32'd7, -32'sd2, 0);
    run_div(1'b0, 32'h1234, 32'd0, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(1'b1, -32'sd5, 32'd0, 0);
    run_div(1'b1, -32'sd6, -32'sd3, 0);
    run_div(1'b0, 32'd3, 32'd10, 0);
    run_div(1'b0, 32'd100, 32'd7, 1);
    idle_cycles(W + 8);
    run_abort(32'd1000, 32'd7);
    run_div(1'b0, 32'd9, 32'd3, 0);

    for (int i = 0; i < 50; i++) begin
      s = 1'($urandom_range(1));
      a = $urandom;
      case ($urandom_range(3))
        0: b = 32'($urandom_range(15));
        1: b = -32'($urandom_range(15));
        default: b = $urandom;
      endcase
      if ($urandom_range(7) == 0) a = 32'h8000_0000;
      run_div(s, a, b, 0);
    end

    idle_cycles(5);
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
